instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of instruction decode/register select.
- Holds the program counter and issues in-order word fetches to instruction memory over a valid/ready request channel, taking responses on a valid-only channel.
- Buffers fetched words in a small FIFO and presents the head entry to decode, both as a raw word and as split RISC-V fields (opcode, RD, Funct3, RS1, RS2, Funct7).
- Supports PC redirect (branch/jump) with flush and dropping of stale in-flight responses.

---
 rtl/instr_fetch_unit.sv | 186 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches under a
// credit limit, buffers returned words in a small FIFO and presents the head
// entry (raw word plus split RISC-V fields) to decode. A redirect flushes the
// buffer and marks every in-flight response as stale so it is dropped on return.
module instr_fetch_unit #(
    parameter int unsigned     WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_resp_valid,
    input  logic [31:0]      imem_resp_data,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             dec_valid,
    input  logic             dec_ready,
    output logic [WIDTH-1:0] dec_pc,
    output logic [31:0]      dec_instr,
    output logic [6:0]       opcode,
    output logic [4:0]       RD,
    output logic [2:0]       Funct3,
    output logic [4:0]       RS1,
    output logic [4:0]       RS2,
    output logic [6:0]       Funct7
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    // Architectural fetch state
    logic [WIDTH-1:0] pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop;

    // Instruction buffer (PC + word per entry)
    logic [WIDTH-1:0] buf_pc    [DEPTH];
    logic [31:0]      buf_instr [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] occ;

    // PCs of accepted requests, in issue order, consumed by returning responses
    logic [WIDTH-1:0] addr_q [DEPTH];
    logic [PTR_W-1:0] a_rd_ptr;
    logic [PTR_W-1:0] a_wr_ptr;

    // Handshake / control terms
    logic             credit_ok;
    logic             req_fire;
    logic             resp_take;
    logic             resp_drop;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_push;
    logic             fifo_wr;
    logic             pop;
    logic [WIDTH-1:0] redirect_aligned;
    logic [WIDTH-1:0] pc_next_seq;
    logic [CNT_W-1:0] out_after_resp;

    // Request channel: issue whenever credit remains and no redirect is in progress
    always_comb begin
        credit_ok      = (SUM_W'(occ) + SUM_W'(outstanding)) < SUM_W'(DEPTH);
        imem_req_valid = !rst && !redirect_valid && credit_ok;
        imem_req_addr  = pc;
        req_fire       = imem_req_valid && imem_req_ready;
    end

    // Response classification: responses with nothing outstanding are ignored
    always_comb begin
        resp_take      = imem_resp_valid && (outstanding != '0);
        resp_drop      = resp_take && (drop != '0);
        out_after_resp = outstanding - CNT_W'(resp_take);
    end

    // Buffer status and push/pop qualification
    always_comb begin
        fifo_empty = (occ == '0);
        fifo_full  = (occ == CNT_W'(DEPTH));
        dec_valid  = !fifo_empty;
        pop        = dec_valid && dec_ready;
        // A push in a redirect cycle would be flushed at the same edge anyway
        fifo_push  = resp_take && !resp_drop && !redirect_valid;
        fifo_wr    = fifo_push && (!fifo_full || pop);
    end

    // Next PC candidates
    always_comb begin
        redirect_aligned = redirect_pc & ~WIDTH'(3);
        pc_next_seq      = pc + WIDTH'(4);
    end

    // Head-of-buffer presentation to decode, zero when empty
    always_comb begin
        dec_pc    = '0;
        dec_instr = '0;
        if (dec_valid) begin
            dec_pc    = buf_pc[rd_ptr];
            dec_instr = buf_instr[rd_ptr];
        end
    end

    // RISC-V field split of the presented word
    always_comb begin
        opcode = dec_instr[6:0];
        RD     = dec_instr[11:7];
        Funct3 = dec_instr[14:12];
        RS1    = dec_instr[19:15];
        RS2    = dec_instr[24:20];
        Funct7 = dec_instr[31:25];
    end

    // PC, credit counters and drop count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(resp_take);
            if (redirect_valid) begin
                pc   <= redirect_aligned;
                // Everything still in flight after this cycle is stale
                drop <= out_after_resp;
            end else begin
                if (req_fire) begin
                    pc <= pc_next_seq;
                end
                drop <= drop - CNT_W'(resp_drop);
            end
        end
    end

    // Request-address queue pointers; stale entries retire with their dropped responses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rd_ptr <= '0;
            a_wr_ptr <= '0;
        end else begin
            if (req_fire) begin
                a_wr_ptr <= a_wr_ptr + PTR_W'(1);
            end
            if (resp_take) begin
                a_rd_ptr <= a_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Instruction buffer pointers and occupancy, cleared by redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occ <= occ + CNT_W'(fifo_wr) - CNT_W'(pop);
        end
    end

    // Storage arrays, no reset needed: validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (req_fire) begin
            addr_q[a_wr_ptr] <= pc;
        end
        if (fifo_wr) begin
            buf_pc[wr_ptr]    <= addr_q[a_rd_ptr];
            buf_instr[wr_ptr] <= imem_resp_data;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with a fixed-latency in-order memory model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic [6:0]  opcode;
    logic [4:0]  RD;
    logic [2:0]  Funct3;
    logic [4:0]  RS1;
    logic [4:0]  RS2;
    logic [6:0]  Funct7;

    int nvec = 0;
    int nerr = 0;

    instr_fetch_unit #(.WIDTH(32), .RESET_PC(32'h0), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_pc(dec_pc), .dec_instr(dec_instr),
        .opcode(opcode), .RD(RD), .Funct3(Funct3),
        .RS1(RS1), .RS2(RS2), .Funct7(Funct7)
    );

    always #5 clk = ~clk;

    // Memory contents: one hand-picked word, everything else derived from the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0008) return 32'h00A3_0293;
        return a ^ 32'h5A5A_0013;
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t pending[$];
    int    mem_lat = 1;
    int    cyc = 0;

    // Memory model: accept sampled mid-cycle, response driven just after the edge
    initial begin
        pend_t p;
        forever begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                p.addr = imem_req_addr;
                p.due  = cyc + mem_lat;
                pending.push_back(p);
            end
            @(posedge clk);
            cyc++;
            #1;
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
            if (pending.size() > 0 && pending[0].due <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(pending[0].addr);
                void'(pending.pop_front());
            end
        end
    end

    // Buffer must never take a push while full unless it also pops
    always @(negedge clk) begin
        if (!rst && dut.fifo_push && dut.fifo_full && !dut.pop) begin
            nvec++;
            nerr++;
            $display("FAIL overflow_push: push=%0b full=%0b pop=%0b required no push into full buffer",
                     dut.fifo_push, dut.fifo_full, dut.pop);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc_start();
        @(posedge clk);
        #2;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset(input int lat, input logic dr);
        cyc_start();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        dec_ready      = dr;
        mem_lat        = lat;
        pending.delete();
        cyc_start();
        cyc_start();
        rst = 1'b0;
    endtask

    // Advance cycle by cycle until decode shows a valid head or the budget runs out
    task automatic wait_dec(output logic [31:0] pc, output logic [31:0] ins, output bit ok);
        ok  = 1'b0;
        pc  = '0;
        ins = '0;
        for (int n = 0; n < 30; n++) begin
            cyc_start();
            mid();
            if (dec_valid) begin
                pc  = dec_pc;
                ins = dec_instr;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        cyc_start();
        rst = 1'b1;
        mid();
        nvec++; if (imem_req_valid !== 1'b0) begin nerr++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
        nvec++; if (dec_valid !== 1'b0) begin nerr++; $display("FAIL reset_dec_valid: got %b want 0", dec_valid); end
        nvec++; if (dec_pc !== 32'h0) begin nerr++; $display("FAIL reset_dec_pc: got %h want 00000000", dec_pc); end
        nvec++; if (dec_instr !== 32'h0) begin nerr++; $display("FAIL reset_dec_instr: got %h want 00000000", dec_instr); end
        nvec++; if ({opcode, RD, Funct3, RS1, RS2, Funct7} !== 32'h0) begin nerr++; $display("FAIL reset_fields: got %h want 0", {opcode, RD, Funct3, RS1, RS2, Funct7}); end
        cyc_start();
        rst = 1'b0;
        mid();
        nvec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin nerr++; $display("FAIL reset_first_req: got v=%b a=%h want v=1 a=00000000", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        do_reset(1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) cyc_start();
            mid();
            nvec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * i)) begin nerr++; $display("FAIL stream_req[%0d]: got v=%b a=%h want v=1 a=%h", i, imem_req_valid, imem_req_addr, 32'(4 * i)); end
            if (i < 2) begin
                nvec++; if (dec_valid !== 1'b0) begin nerr++; $display("FAIL stream_fill[%0d]: dec_valid got %b want 0", i, dec_valid); end
            end else begin
                exp_pc = 32'(4 * (i - 2));
                nvec++; if (dec_valid !== 1'b1 || dec_pc !== exp_pc) begin nerr++; $display("FAIL stream_dec[%0d]: got v=%b pc=%h want v=1 pc=%h", i, dec_valid, dec_pc, exp_pc); end
                nvec++; if (dec_instr !== mem_word(exp_pc)) begin nerr++; $display("FAIL stream_instr[%0d]: got %h want %h", i, dec_instr, mem_word(exp_pc)); end
            end
            if (i == 4) begin
                nvec++; if (opcode !== 7'h13 || RD !== 5'd5 || Funct3 !== 3'd0 || RS1 !== 5'd6 || RS2 !== 5'd10 || Funct7 !== 7'd0) begin
                    nerr++; $display("FAIL stream_fields: got op=%h rd=%0d f3=%0d rs1=%0d rs2=%0d f7=%0d want op=13 rd=5 f3=0 rs1=6 rs2=10 f7=0", opcode, RD, Funct3, RS1, RS2, Funct7);
                end
            end
        end
    endtask

    task automatic test_stall();
        int acc = 0;
        do_reset(1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i > 0) cyc_start();
            mid();
            if (imem_req_valid && imem_req_ready) acc++;
        end
        nvec++; if (acc !== 4) begin nerr++; $display("FAIL stall_accepts: got %0d want 4", acc); end
        nvec++; if (imem_req_valid !== 1'b0) begin nerr++; $display("FAIL stall_req_valid: got %b want 0", imem_req_valid); end
        nvec++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin nerr++; $display("FAIL stall_hold: got v=%b pc=%h want v=1 pc=00000000", dec_valid, dec_pc); end
        for (int k = 0; k < 5; k++) begin
            cyc_start();
            if (k == 0) dec_ready = 1'b1;
            mid();
            nvec++; if (dec_valid !== 1'b1 || dec_pc !== 32'(4 * k)) begin nerr++; $display("FAIL stall_drain[%0d]: got v=%b pc=%h want v=1 pc=%h", k, dec_valid, dec_pc, 32'(4 * k)); end
        end
    endtask

    task automatic test_redirect();
        logic [31:0] pc;
        logic [31:0] ins;
        bit          ok;
        do_reset(3, 1'b1);
        mid();
        cyc_start();
        mid();
        cyc_start();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        mid();
        nvec++; if (imem_req_valid !== 1'b0) begin nerr++; $display("FAIL redir_no_req: got %b want 0", imem_req_valid); end
        cyc_start();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        mid();
        nvec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin nerr++; $display("FAIL redir_first_req: got v=%b a=%h want v=1 a=00000100", imem_req_valid, imem_req_addr); end
        wait_dec(pc, ins, ok);
        nvec++; if (!ok || pc !== 32'h100 || ins !== mem_word(32'h100)) begin nerr++; $display("FAIL redir_dec0: got ok=%b pc=%h ins=%h want pc=00000100 ins=%h", ok, pc, ins, mem_word(32'h100)); end
        wait_dec(pc, ins, ok);
        nvec++; if (!ok || pc !== 32'h104 || ins !== mem_word(32'h104)) begin nerr++; $display("FAIL redir_dec1: got ok=%b pc=%h ins=%h want pc=00000104 ins=%h", ok, pc, ins, mem_word(32'h104)); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pc;
        logic [31:0] ins;
        bit          ok;
        do_reset(3, 1'b1);
        mid();
        cyc_start();
        mid();
        cyc_start();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        mid();
        cyc_start();
        redirect_pc = 32'h0000_0504;
        mid();
        nvec++; if (imem_req_valid !== 1'b0) begin nerr++; $display("FAIL b2b_no_req: got %b want 0", imem_req_valid); end
        cyc_start();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        mid();
        nvec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h504) begin nerr++; $display("FAIL b2b_first_req: got v=%b a=%h want v=1 a=00000504", imem_req_valid, imem_req_addr); end
        wait_dec(pc, ins, ok);
        nvec++; if (!ok || pc !== 32'h504) begin nerr++; $display("FAIL b2b_dec0: got ok=%b pc=%h want pc=00000504", ok, pc); end
        wait_dec(pc, ins, ok);
        nvec++; if (!ok || pc !== 32'h508) begin nerr++; $display("FAIL b2b_dec1: got ok=%b pc=%h want pc=00000508", ok, pc); end
    endtask

    task automatic test_redirect_coincident();
        logic [31:0] pc;
        logic [31:0] ins;
        bit          ok;
        do_reset(1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) cyc_start();
            mid();
        end
        cyc_start();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        mid();
        nvec++; if (dec_valid !== 1'b1 || dec_pc !== 32'h10 || imem_resp_valid !== 1'b1) begin nerr++; $display("FAIL coin_setup: got v=%b pc=%h resp=%b want v=1 pc=00000010 resp=1", dec_valid, dec_pc, imem_resp_valid); end
        nvec++; if (imem_req_valid !== 1'b0) begin nerr++; $display("FAIL coin_no_req: got %b want 0", imem_req_valid); end
        cyc_start();
        redirect_valid = 1'b0;
        mid();
        nvec++; if (dec_valid !== 1'b0) begin nerr++; $display("FAIL coin_flush: dec_valid got %b want 0", dec_valid); end
        nvec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin nerr++; $display("FAIL coin_first_req: got v=%b a=%h want v=1 a=00000200", imem_req_valid, imem_req_addr); end
        wait_dec(pc, ins, ok);
        nvec++; if (!ok || pc !== 32'h200 || ins !== mem_word(32'h200)) begin nerr++; $display("FAIL coin_dec0: got ok=%b pc=%h ins=%h want pc=00000200", ok, pc, ins); end
        wait_dec(pc, ins, ok);
        nvec++; if (!ok || pc !== 32'h204) begin nerr++; $display("FAIL coin_dec1: got ok=%b pc=%h want pc=00000204", ok, pc); end
    endtask

    task automatic test_async_reset();
        logic [31:0] pc;
        logic [31:0] ins;
        bit          ok;
        do_reset(3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc_start();
            mid();
        end
        cyc_start();
        imem_req_ready = 1'b0;
        mid();
        nvec++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin nerr++; $display("FAIL arst_pre: got v=%b pc=%h want v=1 pc=00000000", dec_valid, dec_pc); end
        #1;
        rst = 1'b1;
        #1;
        nvec++; if (dec_valid !== 1'b0 || imem_req_valid !== 1'b0) begin nerr++; $display("FAIL arst_immediate: got dv=%b rv=%b want 0 0", dec_valid, imem_req_valid); end
        nvec++; if (dec_pc !== 32'h0 || dec_instr !== 32'h0 || opcode !== 7'h0 || RD !== 5'h0) begin nerr++; $display("FAIL arst_outputs: got pc=%h ins=%h op=%h rd=%h want all 0", dec_pc, dec_instr, opcode, RD); end
        cyc_start();
        rst = 1'b0;
        mid();
        nvec++; if (dec_valid !== 1'b0) begin nerr++; $display("FAIL arst_late0: dec_valid got %b want 0", dec_valid); end
        nvec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin nerr++; $display("FAIL arst_restart_req: got v=%b a=%h want v=1 a=00000000", imem_req_valid, imem_req_addr); end
        cyc_start();
        mid();
        nvec++; if (dec_valid !== 1'b0) begin nerr++; $display("FAIL arst_late1: dec_valid got %b want 0", dec_valid); end
        cyc_start();
        mid();
        nvec++; if (dec_valid !== 1'b0) begin nerr++; $display("FAIL arst_late2: dec_valid got %b want 0", dec_valid); end
        cyc_start();
        imem_req_ready = 1'b1;
        dec_ready      = 1'b1;
        mid();
        wait_dec(pc, ins, ok);
        nvec++; if (!ok || pc !== 32'h0 || ins !== mem_word(32'h0)) begin nerr++; $display("FAIL arst_dec0: got ok=%b pc=%h ins=%h want pc=00000000 ins=%h", ok, pc, ins, mem_word(32'h0)); end
        wait_dec(pc, ins, ok);
        nvec++; if (!ok || pc !== 32'h4) begin nerr++; $display("FAIL arst_dec1: got ok=%b pc=%h want pc=00000004", ok, pc); end
    endtask

    task automatic test_wrap();
        logic [31:0] pc;
        logic [31:0] ins;
        bit          ok;
        do_reset(1, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        mid();
        cyc_start();
        redirect_valid = 1'b0;
        mid();
        nvec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin nerr++; $display("FAIL wrap_req0: got v=%b a=%h want v=1 a=fffffffc", imem_req_valid, imem_req_addr); end
        cyc_start();
        mid();
        nvec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin nerr++; $display("FAIL wrap_req1: got v=%b a=%h want v=1 a=00000000", imem_req_valid, imem_req_addr); end
        wait_dec(pc, ins, ok);
        nvec++; if (!ok || pc !== 32'hFFFF_FFFC || ins !== mem_word(32'hFFFF_FFFC)) begin nerr++; $display("FAIL wrap_dec0: got ok=%b pc=%h ins=%h want pc=fffffffc", ok, pc, ins); end
        wait_dec(pc, ins, ok);
        nvec++; if (!ok || pc !== 32'h0) begin nerr++; $display("FAIL wrap_dec1: got ok=%b pc=%h want pc=00000000", ok, pc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_redirect_coincident();
        test_async_reset();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
